// File: rtl/interrupt_controller.sv
// Eight-level priority interrupt controller: synchronises irq lines, latches requests
// into a pending register and tracks nested in-service levels for the control unit.
module interrupt_controller #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq,
  input  logic [7:0] mask,
  input  logic [7:0] s_calli,
  input  logic [7:0] s_reti,
  output logic [7:0] max_bit_s,
  output logic [7:0] max_bit_a,
  output logic [7:0] pending,
  output logic [2:0] irq_index
);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [SYNC_STAGES:0]        prime_q;
  logic [7:0] sync, sync_d, rise_q, active, set_vec, eligible, cand;
  logic       accept, ret;

  function automatic logic [7:0] top_one_hot(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  assign sync = sync_q[SYNC_STAGES-1];

  // prime_q fills with ones after reset; a rise only counts once sync_d holds a real
  // post-reset sample, so a line held high through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= '0;
      sync_d  <= '0;
      rise_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q[0] <= irq;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      sync_d  <= sync;
      rise_q  <= sync & ~sync_d & {8{prime_q[SYNC_STAGES]}};
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign set_vec = EDGE_MODE ? rise_q : sync;
  assign accept  = (s_calli != 8'h00) && ((s_calli & active) == 8'h00);
  assign ret     = (s_reti & active) != 8'h00;

  // A new request on the accepted bit wins; a return clears before an accept sets.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
      active  <= '0;
    end else begin
      pending <= (pending & ~(accept ? s_calli : 8'h00)) | set_vec;
      active  <= (active & ~(ret ? s_reti : 8'h00)) | (accept ? s_calli : 8'h00);
    end
  end

  always_comb begin
    eligible  = pending & mask;
    cand      = top_one_hot(eligible);
    max_bit_a = top_one_hot(active);
    max_bit_s = (cand > max_bit_a) ? cand : max_bit_a;
    irq_index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (max_bit_s[i]) irq_index = 3'(i);
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus randomised
// traffic, all compared against a sample-history reference model.
module tb_interrupt_controller;

  localparam int L = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq, mask, s_calli, s_reti;
  logic [7:0] max_bit_s, max_bit_a, pending;
  logic [2:0] irq_index;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] hist[$];
  logic [7:0] m_pend, m_act;

  interrupt_controller #(.SYNC_STAGES(L), .EDGE_MODE(1'b1)) dut (
    .clk(clk), .reset(reset), .irq(irq), .mask(mask), .s_calli(s_calli),
    .s_reti(s_reti), .max_bit_s(max_bit_s), .max_bit_a(max_bit_a),
    .pending(pending), .irq_index(irq_index)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] highest(input logic [7:0] v);
    int p = 1;
    if (v == 8'h00) return 8'h00;
    while (p * 2 <= int'(v)) p = p * 2;
    return 8'(p);
  endfunction

  // Samples are numbered from the first edge after reset; a 0->1 between samples
  // k-1 and k becomes pending at edge k+L+1.
  task automatic modelEdge();
    int n;
    logic [7:0] set_v, acc_v, ret_v;
    if (!reset) begin
      m_pend = 8'h00;
      m_act  = 8'h00;
      hist.delete();
    end else begin
      hist.push_back(irq);
      n     = hist.size();
      set_v = 8'h00;
      if (n - (L + 2) >= 1) set_v = hist[n-(L+1)-1] & ~hist[n-(L+2)-1];
      acc_v = (s_calli != 8'h00 && (s_calli & m_act) == 8'h00) ? s_calli : 8'h00;
      ret_v = ((s_reti & m_act) != 8'h00) ? s_reti : 8'h00;
      m_pend = (m_pend & ~acc_v) | set_v;
      m_act  = (m_act & ~ret_v) | acc_v;
    end
  endtask

  task automatic checkModel();
    logic [7:0] ma, mc, ms;
    ma = highest(m_act);
    mc = highest(m_pend & mask);
    ms = (mc > ma) ? mc : ma;
    checkOutput("pending", pending, m_pend);
    checkOutput("max_bit_a", max_bit_a, ma);
    checkOutput("max_bit_s", max_bit_s, ms);
    checkOutput("irq_index", {5'd0, irq_index}, (ms == 8'h00) ? 8'h00 : 8'($clog2(ms)));
  endtask

  task automatic applyStimulus(input logic [7:0] i, input logic [7:0] m, input logic [7:0] c,
                               input logic [7:0] r, input logic rst_n);
    @(negedge clk);
    irq = i; mask = m; s_calli = c; s_reti = r; reset = rst_n;
    @(posedge clk);
    modelEdge();
    #1;
    checkModel();
  endtask

  task automatic step(input logic [7:0] i, input logic [7:0] c, input logic [7:0] r);
    applyStimulus(i, mask, c, r, 1'b1);
  endtask

  task automatic doReset();
    applyStimulus(8'h00, mask, 8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, mask, 8'h00, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) step(8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] ri, rc, rr;
    irq = 8'h00; mask = 8'hFF; s_calli = 8'h00; s_reti = 8'h00; reset = 1'b0;
    m_pend = 8'h00; m_act = 8'h00;

    doReset();
    checkOutput("reset_s", max_bit_s, 8'h00);
    checkOutput("reset_pend", pending, 8'h00);

    // Basic request, latency and accept
    step(8'h04, 8'h00, 8'h00);
    step(8'h00, 8'h00, 8'h00);
    step(8'h00, 8'h00, 8'h00);
    checkOutput("latency_not_yet", max_bit_s, 8'h00);
    step(8'h00, 8'h00, 8'h00);
    checkOutput("basic_s", max_bit_s, 8'h04);
    checkOutput("basic_idx", {5'd0, irq_index}, 8'h02);
    step(8'h00, 8'h04, 8'h00);
    checkOutput("basic_a", max_bit_a, 8'h04);
    checkOutput("basic_pend", pending, 8'h00);
    checkOutput("basic_s2", max_bit_s, 8'h04);

    // Nesting
    step(8'h40, 8'h04, 8'h00);
    for (int k = 0; k < 3; k++) step(8'h00, 8'h04, 8'h00);
    checkOutput("nest_s", max_bit_s, 8'h40);
    step(8'h00, 8'h40, 8'h00);
    checkOutput("nest_a", max_bit_a, 8'h40);
    step(8'h00, 8'h00, 8'h40);
    checkOutput("nest_ret6", max_bit_a, 8'h04);
    step(8'h00, 8'h00, 8'h04);
    checkOutput("nest_ret2", max_bit_a, 8'h00);

    // No preemption by a lower level
    step(8'h00, 8'h40, 8'h00);
    step(8'h02, 8'h40, 8'h00);
    for (int k = 0; k < 3; k++) step(8'h00, 8'h40, 8'h00);
    checkOutput("nopre_s", max_bit_s, 8'h40);
    checkOutput("nopre_pend", pending, 8'h02);
    step(8'h00, 8'h00, 8'h40);
    checkOutput("nopre_after", max_bit_s, 8'h02);

    // Mask holds a request pending; unmasking is immediate
    mask = 8'hFF;
    doReset();
    mask = 8'h00;
    step(8'h80, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) step(8'h00, 8'h00, 8'h00);
    checkOutput("mask_pend", pending, 8'h80);
    checkOutput("mask_s", max_bit_s, 8'h00);
    @(negedge clk);
    mask = 8'h80;
    #1;
    checkOutput("unmask_s", max_bit_s, 8'h80);
    mask = 8'hFF;

    // Held accept with a fresh request on the same level
    doReset();
    step(8'h08, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) step(8'h00, 8'h00, 8'h00);
    for (int k = 1; k <= 5; k++) step((k == 3) ? 8'h08 : 8'h00, 8'h08, 8'h00);
    for (int k = 0; k < 3; k++) step(8'h00, 8'h00, 8'h00);
    checkOutput("held_pend", pending, 8'h08);
    checkOutput("held_a", max_bit_a, 8'h08);

    // Reset mid-service, irq held high through reset
    doReset();
    step(8'h00, 8'h04, 8'h00);
    step(8'h00, 8'h20, 8'h00);
    step(8'h81, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) step(8'h00, 8'h00, 8'h00);
    checkOutput("pre_rst_pend", pending, 8'h81);
    checkOutput("pre_rst_a", max_bit_a, 8'h20);
    applyStimulus(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);
    checkOutput("rst_s", max_bit_s, 8'h00);
    checkOutput("rst_a", max_bit_a, 8'h00);
    checkOutput("rst_pend", pending, 8'h00);
    checkOutput("rst_idx", {5'd0, irq_index}, 8'h00);
    for (int k = 0; k < 8; k++) step(8'hFF, 8'h00, 8'h00);
    checkOutput("held_high_pend", pending, 8'h00);
    for (int k = 0; k < 3; k++) step(8'h00, 8'h00, 8'h00);
    step(8'hFF, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) step(8'hFF, 8'h00, 8'h00);
    checkOutput("rearm_pend", pending, 8'hFF);

    // Randomised traffic
    ri = 8'h00;
    for (int k = 0; k < 1500; k++) begin
      ri = ri ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      rc = ($urandom_range(3) == 0) ? (8'h01 << $urandom_range(7)) : 8'h00;
      rr = ($urandom_range(2) == 0) ? (8'h01 << $urandom_range(7)) : 8'h00;
      applyStimulus(ri, ($urandom_range(4) == 0) ? 8'($urandom) : 8'hFF, rc, rr,
                    ($urandom_range(99) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
